// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI slave.
package spi_pkg;

    // Frame width in bits
    localparam int SPI_BITS = 8;

    // Byte shifted out when the holding register is empty
    localparam logic [SPI_BITS-1:0] IDLE_BYTE_DEFAULT = 8'hFF;

    // Link state follows the synchronized slave select
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input, with a selectable reset value.
module spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the raw input through the flop chain; the last stage is the synchronized value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave: 8-bit MSB-first frames, one-deep TX holding register,
// RX byte output with valid pulse, ack and sticky overrun flag.
//
// Handshakes: tx_wr is a one-cycle strobe accepted only while tx_full=0;
// rx_valid pulses for one cycle per completed byte and the consumer answers
// with rx_ack (any later cycle) -- a second byte completing before that ack
// sets rx_overrun, which rx_ack also clears.
module spi_slave
    import spi_pkg::*;
#(
    parameter int                  SYNC_STAGES = 2,
    parameter logic [SPI_BITS-1:0] IDLE_BYTE   = IDLE_BYTE_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sck,
    input  logic                ss_n,
    input  logic                mosi,
    output logic                miso,
    output logic                miso_oe,
    input  logic [SPI_BITS-1:0] tx_data,
    input  logic                tx_wr,
    output logic                tx_full,
    output logic [SPI_BITS-1:0] rx_data,
    output logic                rx_valid,
    output logic                rx_overrun,
    input  logic                rx_ack
);

    localparam int               CNT_W         = $clog2(SPI_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT      = CNT_W'(SPI_BITS - 1);
    localparam logic [7:0]       SETTLE_CYCLES = 8'(SYNC_STAGES);

    // Synchronized pins
    logic sck_s;
    logic ss_n_s;
    logic mosi_s;

    // Edge detection
    logic [7:0] settle_cnt;
    logic       settled;
    logic       sck_prev;
    logic       ss_prev;
    logic       sck_rise_p;
    logic       sck_fall_p;
    logic       ss_fall_p;
    logic       ss_rise_p;
    logic       mosi_p;

    // Link state and datapath
    spi_state_t          state;
    logic [CNT_W-1:0]    bit_cnt;
    logic [SPI_BITS-2:0] rx_shift;
    logic [SPI_BITS-1:0] tx_shift;
    logic [SPI_BITS-1:0] tx_hold;
    logic                reload_pend;
    logic                rx_pend;

    logic                do_load;
    logic                rx_done;
    logic [SPI_BITS-1:0] load_byte;
    logic [SPI_BITS-1:0] rx_byte;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk   (clk),
        .reset (reset),
        .d     (sck),
        .q     (sck_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk   (clk),
        .reset (reset),
        .d     (ss_n),
        .q     (ss_n_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk   (clk),
        .reset (reset),
        .d     (mosi),
        .q     (mosi_s)
    );

    // Count out the synchronizer flush after reset so its reset value is never mistaken for a select edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle_cnt <= 8'd0;
        end else if (!settled) begin
            settle_cnt <= settle_cnt + 8'd1;
        end
    end

    assign settled = (settle_cnt == SETTLE_CYCLES);

    // Register one-cycle edge pulses; ss_prev is held low until settled, so a select
    // already low at reset release needs a real high-then-low before it counts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_prev   <= 1'b0;
            ss_prev    <= 1'b0;
            sck_rise_p <= 1'b0;
            sck_fall_p <= 1'b0;
            ss_fall_p  <= 1'b0;
            ss_rise_p  <= 1'b0;
            mosi_p     <= 1'b0;
        end else begin
            sck_prev   <= sck_s;
            ss_prev    <= settled ? ss_n_s : 1'b0;
            sck_rise_p <= sck_s & ~sck_prev;
            sck_fall_p <= ~sck_s & sck_prev;
            ss_fall_p  <= ss_prev & ~ss_n_s;
            ss_rise_p  <= ss_n_s & ~ss_prev;
            mosi_p     <= mosi_s;
        end
    end

    assign load_byte = tx_full ? tx_hold : IDLE_BYTE;
    assign rx_byte   = {rx_shift, mosi_p};
    assign do_load   = ((state == ST_IDLE) && ss_fall_p) ||
                       ((state == ST_ACTIVE) && !ss_rise_p && sck_fall_p && reload_pend);
    assign rx_done   = (state == ST_ACTIVE) && !ss_rise_p && sck_rise_p && (bit_cnt == LAST_BIT);

    // Link FSM with TX/RX shifters, holding register and RX handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '1;
            tx_hold     <= '0;
            tx_full     <= 1'b0;
            reload_pend <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_pend     <= 1'b0;
            rx_overrun  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;

            // A load empties a full holding register; a write lands only when it is empty
            if (do_load && tx_full) begin
                tx_full <= 1'b0;
            end else if (tx_wr && !tx_full) begin
                tx_hold <= tx_data;
                tx_full <= 1'b1;
            end

            if (rx_done) begin
                rx_data  <= rx_byte;
                rx_valid <= 1'b1;
                rx_pend  <= 1'b1;
                if (rx_pend && !rx_ack) begin
                    rx_overrun <= 1'b1;
                end else if (rx_ack) begin
                    rx_overrun <= 1'b0;
                end
            end else if (rx_ack) begin
                rx_pend    <= 1'b0;
                rx_overrun <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (ss_fall_p) begin
                        state       <= ST_ACTIVE;
                        tx_shift    <= load_byte;
                        bit_cnt     <= '0;
                        reload_pend <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (ss_rise_p) begin
                        state       <= ST_IDLE;
                        bit_cnt     <= '0;
                        reload_pend <= 1'b0;
                    end else if (sck_rise_p) begin
                        rx_shift <= rx_byte[SPI_BITS-2:0];
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            reload_pend <= 1'b1;
                        end
                    end else if (sck_fall_p) begin
                        if (reload_pend) begin
                            tx_shift    <= load_byte;
                            reload_pend <= 1'b0;
                        end else begin
                            tx_shift <= {tx_shift[SPI_BITS-2:0], 1'b0};
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign miso_oe = (state == ST_ACTIVE);
    assign miso    = (state == ST_ACTIVE) ? tx_shift[SPI_BITS-1] : 1'b1;

endmodule

// File: tb/tb_spi_slave.sv
// Randomized bench for spi_slave against a byte-level model of the link.
module tb_spi_slave;

    localparam int         SYNC_STAGES = 2;
    localparam logic [7:0] IDLE        = 8'hFF;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sck = 1'b0;
    logic       ss_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_wr = 1'b0;
    logic       tx_full;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_overrun;
    logic       rx_ack = 1'b0;

    spi_slave #(.SYNC_STAGES(SYNC_STAGES), .IDLE_BYTE(IDLE)) dut (
        .clk        (clk),
        .reset      (reset),
        .sck        (sck),
        .ss_n       (ss_n),
        .mosi       (mosi),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .tx_data    (tx_data),
        .tx_wr      (tx_wr),
        .tx_full    (tx_full),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_overrun (rx_overrun),
        .rx_ack     (rx_ack)
    );

    // clock and cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // model state and scoreboard
    logic [7:0] exp_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] mosi_buf[4];
    bit         model_pend = 1'b0;
    bit         exp_ovr = 1'b0;
    bit         auto_ack = 1'b1;
    int         last_rise_cyc = 0;
    int         n_valid = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // inspect receive-side outputs once per cycle
    task automatic sample_rx();
        if (rx_valid) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                chk("rx_spurious", 32'(exp_q.size()), 32'd1);
            end else begin
                chk("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
                chk("rx_latency", 32'(cyc - last_rise_cyc), 32'(SYNC_STAGES + 2));
                chk("rx_overrun", 32'(rx_overrun), 32'(exp_ovr));
            end
        end
    endtask

    // every wait goes through here: drops rx_ack after one cycle and watches rx_valid
    task automatic wait_clk(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_ack = 1'b0;
            sample_rx();
        end
    endtask

    task automatic model_load(output logic [7:0] b);
        if (tx_q.size() > 0) b = tx_q.pop_front();
        else b = IDLE;
    endtask

    task automatic do_tx_wr(input logic [7:0] d);
        tx_data = d;
        tx_wr   = 1'b1;
        if (tx_q.size() == 0) tx_q.push_back(d);
        wait_clk(1);
        tx_wr = 1'b0;
        chk("tx_full_wr", 32'(tx_full), 32'(tx_q.size() != 0));
    endtask

    task automatic check_reset_state();
        chk("rst_miso", 32'(miso), 32'd1);
        chk("rst_miso_oe", 32'(miso_oe), 32'd0);
        chk("rst_tx_full", 32'(tx_full), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_overrun", 32'(rx_overrun), 32'd0);
    endtask

    // master driver: nbits of mode-0 clocking at clk/8, bytes from mosi_buf
    task automatic spi_frame(input int nbits, input bit keep_sel);
        logic [7:0] exp_tx;
        logic [7:0] got;
        int b;
        got  = 8'h00;
        ss_n = 1'b0;
        model_load(exp_tx);
        wait_clk(4);
        for (int i = 0; i < nbits; i++) begin
            b    = i % 8;
            mosi = mosi_buf[i / 8][7 - b];
            wait_clk(4);
            if (i == 0) begin
                chk("miso_oe_sel", 32'(miso_oe), 32'd1);
                chk("tx_full_sel", 32'(tx_full), 32'(tx_q.size() != 0));
            end
            got[7 - b] = miso;
            if (b == 7) begin
                exp_q.push_back(mosi_buf[i / 8]);
                if (model_pend) exp_ovr = 1'b1;
                model_pend = 1'b1;
            end
            sck = 1'b1;
            last_rise_cyc = cyc;
            wait_clk(4);
            sck = 1'b0;
            if (b == 7) begin
                chk("miso_byte", 32'(got), 32'(exp_tx));
                model_load(exp_tx);
                if (auto_ack) begin
                    rx_ack     = 1'b1;
                    model_pend = 1'b0;
                    exp_ovr    = 1'b0;
                end
            end
        end
        wait_clk(4);
        if (!keep_sel) begin
            ss_n = 1'b1;
            wait_clk(8);
            chk("miso_idle", 32'(miso), 32'd1);
            chk("miso_oe_idle", 32'(miso_oe), 32'd0);
        end
    endtask

    int v0;
    int nb;
    int nbits;

    initial begin
        // reset
        wait_clk(3);
        reset = 1'b0;
        wait_clk(1);
        check_reset_state();
        wait_clk(4);

        // A5 out, 3C in
        do_tx_wr(8'hA5);
        mosi_buf[0] = 8'h3C;
        v0 = n_valid;
        spi_frame(8, 1'b0);
        chk("pulses_single", 32'(n_valid - v0), 32'd1);
        chk("rx_data_hold", 32'(rx_data), 32'h3C);

        // two frames without ack or tx_wr
        auto_ack = 1'b0;
        v0 = n_valid;
        mosi_buf[0] = 8'h5E;
        spi_frame(8, 1'b0);
        mosi_buf[0] = 8'hC3;
        spi_frame(8, 1'b0);
        chk("pulses_double", 32'(n_valid - v0), 32'd2);
        chk("overrun_sticky", 32'(rx_overrun), 32'd1);
        rx_ack = 1'b1;
        model_pend = 1'b0;
        exp_ovr = 1'b0;
        wait_clk(2);
        chk("overrun_clear", 32'(rx_overrun), 32'd0);
        auto_ack = 1'b1;

        // partial byte then full 81
        v0 = n_valid;
        mosi_buf[0] = 8'($urandom);
        spi_frame(5, 1'b0);
        chk("partial_no_valid", 32'(n_valid - v0), 32'd0);
        mosi_buf[0] = 8'h81;
        spi_frame(8, 1'b0);
        chk("after_partial", 32'(rx_data), 32'h81);

        // second write while full is dropped
        do_tx_wr(8'h11);
        do_tx_wr(8'h22);
        mosi_buf[0] = 8'($urandom);
        spi_frame(8, 1'b0);
        mosi_buf[0] = 8'($urandom);
        spi_frame(8, 1'b0);

        // reset mid-frame with the holding register full
        mosi_buf[0] = 8'($urandom);
        spi_frame(3, 1'b1);
        do_tx_wr(8'h5A);
        reset = 1'b1;
        tx_q.delete();
        exp_q.delete();
        model_pend = 1'b0;
        exp_ovr = 1'b0;
        wait_clk(2);
        check_reset_state();
        reset = 1'b0;
        wait_clk(10);
        chk("no_stale_select", 32'(miso_oe), 32'd0);
        ss_n = 1'b1;
        wait_clk(8);
        mosi_buf[0] = 8'h96;
        spi_frame(8, 1'b0);
        chk("after_reset_rx", 32'(rx_data), 32'h96);

        // random frames: optional tx_wr, one or two bytes per select, occasional partial
        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(0, 1) == 1) do_tx_wr(8'($urandom));
            nb = $urandom_range(1, 2);
            for (int k = 0; k < 4; k++) mosi_buf[k] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) nbits = $urandom_range(1, 7);
            else nbits = nb * 8;
            spi_frame(nbits, 1'b0);
        end

        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
